// File: rtl/ascii_to_binary.sv
// Serial ASCII decimal parser: accumulates one character per handshake into a
// binary value and presents it with overflow/error flags on a held result port.
module ascii_to_binary #(
  parameter int size_binary = 16,
  parameter int max_digits  = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [7:0]             in_char,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [size_binary-1:0] out_value,
  output logic                   out_overflow,
  output logic                   out_error,
  output logic [1:0]             dbg_state
);

  // Handshakes: a character transfers on a rising edge where in_valid and
  // in_ready are both 1; a result transfers where out_valid and out_ready are
  // both 1. out_valid and the result fields stay stable until that transfer.

  typedef enum logic [1:0] {IDLE, ACCUM, DISCARD, DONE} state_t;

  localparam int CW = $clog2(max_digits + 2);
  localparam int WW = size_binary + 4;
  localparam logic [CW-1:0] cnt_max = CW'(max_digits);
  localparam logic [CW-1:0] cnt_one = CW'(1);
  localparam logic [WW-1:0] val_max = {4'b0, {size_binary{1'b1}}};
  localparam logic [WW-1:0] ten     = WW'(10);

  state_t                 state_q, state_d;
  logic [size_binary-1:0] acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   err_q, err_d;
  logic [size_binary-1:0] oval_q, oval_d;
  logic                   oovf_q, oovf_d;
  logic                   oerr_q, oerr_d;

  logic          is_digit, is_term, take;
  logic [WW-1:0] digit_w, next_w;

  assign is_digit = (in_char >= 8'h30) && (in_char <= 8'h39);
  assign is_term  = (in_char == 8'h20) || (in_char == 8'h0D) || (in_char == 8'h0A);
  assign digit_w  = {{size_binary{1'b0}}, in_char[3:0]};
  assign next_w   = ({4'b0, acc_q} * ten) + digit_w;

  assign in_ready     = rst_n && (state_q != DONE);
  assign take         = in_valid && in_ready;
  assign out_valid    = (state_q == DONE);
  assign out_value    = oval_q;
  assign out_overflow = oovf_q;
  assign out_error    = oerr_q;
  assign dbg_state    = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      oval_q  <= '0;
      oovf_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      oval_q  <= oval_d;
      oovf_q  <= oovf_d;
      oerr_q  <= oerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    oval_d  = oval_q;
    oovf_d  = oovf_q;
    oerr_d  = oerr_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          if (is_digit) begin
            acc_d   = digit_w[size_binary-1:0];
            cnt_d   = cnt_one;
            state_d = ACCUM;
          end else if (!is_term) begin
            err_d   = 1'b1;
            state_d = DISCARD;
          end
        end
      end
      ACCUM: begin
        if (take) begin
          if (is_digit) begin
            cnt_d = (cnt_q > cnt_max) ? cnt_q : cnt_q + cnt_one;
            // Once saturated, acc stays all-ones for the rest of the number.
            if ((next_w > val_max) || (cnt_q >= cnt_max)) begin
              ovf_d = 1'b1;
              acc_d = '1;
            end else begin
              acc_d = next_w[size_binary-1:0];
            end
          end else if (is_term) begin
            state_d = DONE;
            oval_d  = ovf_q ? '1 : acc_q;
            oovf_d  = ovf_q;
            oerr_d  = 1'b0;
          end else begin
            err_d   = 1'b1;
            state_d = DISCARD;
          end
        end
      end
      DISCARD: begin
        if (take && is_term) begin
          state_d = DONE;
          oval_d  = '0;
          oovf_d  = ovf_q;
          oerr_d  = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          oval_d  = '0;
          oovf_d  = 1'b0;
          oerr_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/ascii_to_binary.md
Name: ascii_to_binary

Overview:
- Serial ASCII decimal parser. The inverse direction of the binary-to-decimal-ASCII display path.
- Accepts one ASCII character per cycle over a valid/ready handshake and accumulates decimal digits into a binary value.
- On a terminator character, presents the value, plus overflow and error flags, on a held valid/ready output.
- Sits between a character source (UART receive or keypad buffer) and datapath logic that needs numeric operands.

Parameters:
- size_binary, 16, width of the binary result.
- max_digits, 5, maximum decimal digits accepted per number; more digits sets overflow.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_char is valid this cycle.
- in_char  input  8  ASCII character.
- in_ready  output  1  parser can accept a character; a transfer occurs when in_valid and in_ready are both 1.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_value  output  size_binary  parsed binary value.
- out_overflow  output  1  value exceeded 2^size_binary-1 or digit count exceeded max_digits.
- out_error  output  1  a non-digit, non-terminator character was seen.

Behaviour:
- Reset is asynchronous on rst_n low. Reset values:
  - state = IDLE, accumulator = 0, digit count = 0, flags = 0.
  - out_valid = 0, out_value = 0, out_overflow = 0, out_error = 0.
  - in_ready = 0 while rst_n is low; in_ready = 1 on the first cycle after release.
- Character classes:
  - Digit: 0x30-0x39.
  - Terminator: 0x20 (space), 0x0D (CR), 0x0A (LF).
  - Everything else is invalid.
- States: IDLE, ACCUM, DISCARD, DONE. in_ready = 1 in IDLE, ACCUM and DISCARD; in_ready = 0 in DONE.
- IDLE:
  - Digit: acc = digit value, count = 1, go to ACCUM.
  - Terminator: ignored, stay in IDLE (leading separators and empty fields produce no output).
  - Invalid: set error, go to DISCARD.
- ACCUM:
  - Digit: next = acc*10 + digit, computed at size_binary+4 bits.
    - If next > 2^size_binary-1, or count+1 > max_digits: set sticky overflow and hold acc at all-ones.
    - Otherwise acc = next.
    - count increments and saturates at max_digits+1.
  - Terminator: go to DONE.
  - Invalid: set error, go to DISCARD.
- DISCARD: all characters are consumed and dropped until a terminator, which moves to DONE.
- Leading zeros count toward max_digits.
- DONE:
  - out_valid = 1.
  - If error: out_value = 0 and out_error = 1. If overflow without error: out_value = all-ones. out_overflow = the sticky overflow flag.
  - Outputs stay stable until out_ready = 1. On that cycle go to IDLE and clear acc, count and flags.
  - out_valid = 0 and in_ready = 1 on the next cycle.
- Latency: terminator accepted at edge N -> out_valid = 1 after edge N.
- out_value, out_overflow and out_error are registered. They are don't-care when out_valid = 0, but are driven to 0 in IDLE, ACCUM and DISCARD.
- Simultaneous events: no input is accepted in DONE, so a result and a new character never collide. A back-to-back result needs at least one IDLE cycle.
- Reset mid-number discards the partial number; no output is produced.
- in_valid = 0 cycles in any state leave all state unchanged.

Test Plan:
Default parameters; each character is driven for one cycle with in_valid = 1 unless noted.
- "1234" CR, out_ready = 1 -> out_valid 1 cycle after CR; out_value = 0x04D2, overflow = 0, error = 0.
- "65535" space -> out_value = 0xFFFF, overflow = 0.
- "65536" space -> out_value = 0xFFFF, overflow = 1.
- "000001" LF -> overflow = 1 (digit count 6 > 5).
- "  5" LF "  " -> single result out_value = 5. Lone spaces produce no out_valid.
- "12a3" space -> error = 1, out_value = 0. The trailing '3' is discarded.
- "42" space with out_ready = 0 for 5 cycles, in_valid kept high with '7' -> out_valid and out_value = 42 held for 5 cycles; in_ready = 0 throughout; '7' is not consumed. Raise out_ready -> in_ready = 1 next cycle, and '7' is accepted.
- "98", pulse rst_n low mid-cycle, then "7" space -> all outputs 0 immediately on reset; next result out_value = 7.
